// File: rtl/uart_loader_pkg.sv
// Shared types for the UART image loader.
// Frame: 4-byte count, count LE words, 1-byte XOR checksum.
package uart_loader_pkg;

    typedef enum logic [2:0] {
        S_LEN,
        S_DATA,
        S_SUM,
        S_FLUSH,
        S_DONE,
        S_ERR
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_SUM     = 2'd1,
        ERR_LEN     = 2'd2,
        ERR_OVERRUN = 2'd3
    } err_t;

    localparam int FIELD_BYTES = 4;

endpackage

// File: rtl/uart_loader_if.sv
// Memory write handshake between the loader and the image memory.
// A write is accepted when mem_req && mem_ready.
interface uart_loader_if #(
    parameter int ADDR_WIDTH = 32
);

    logic                  mem_req;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic                  mem_ready;

    modport master (
        output mem_req,
        output mem_addr,
        output mem_wdata,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        input  mem_wdata,
        output mem_ready
    );

endinterface

// File: rtl/uart_word_packer.sv
// Packs an LSB-first byte stream into 32-bit words.
// wordValid pulses combinationally with the 4th byte.
module uart_word_packer
    import uart_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byteValid,
    input  logic [7:0]  byteIn,
    output logic [31:0] word,
    output logic        wordValid
);

    logic [1:0]  pos;
    logic [23:0] shift;

    // Only the first three bytes need storing; the
    // fourth is merged straight into the output word.
    assign word      = {byteIn, shift};
    assign wordValid = byteValid
                    && (pos == 2'(FIELD_BYTES - 1));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            pos   <= 2'd0;
            shift <= 24'd0;
        end else if (byteValid) begin
            pos   <= pos + 2'd1;
            shift <= {byteIn, shift[23:8]};
        end
    end

endmodule

// File: rtl/uart_loader.sv
// Parses a framed image from the UART byte stream and
// issues one memory write per word starting at BASE_ADDR.
module uart_loader
    import uart_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          ADDR_WIDTH = 32,
    parameter logic [31:0] MAX_WORDS  = 32'd16384
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           rx_data,
    input  logic                 rx_valid,
    input  logic                 restart,
    uart_loader_if.master        mem,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           error
);

    state_t                state;
    err_t                  errCode;
    logic [31:0]           count;
    logic [31:0]           index;
    logic [7:0]            sum;
    logic                  memReq;
    logic [ADDR_WIDTH-1:0] memAddr;
    logic [31:0]           memWdata;

    logic                  collecting;
    logic                  packValid;
    logic                  packClear;
    logic                  wordValid;
    logic [31:0]           word;
    logic                  accepted;
    logic                  lastWord;
    logic                  stalled;
    logic [ADDR_WIDTH-1:0] addrNext;

    assign collecting = (state == S_LEN)
                     || (state == S_DATA);
    assign packValid  = rx_valid && collecting && !restart;
    assign packClear  = restart || !collecting;
    assign accepted   = memReq && mem.mem_ready;
    assign stalled    = memReq && !mem.mem_ready;
    assign lastWord   = (index + 32'd1) == count;
    assign addrNext   = ADDR_WIDTH'(BASE_ADDR)
                      + ADDR_WIDTH'(index << 2);

    assign mem.mem_req   = memReq;
    assign mem.mem_addr  = memAddr;
    assign mem.mem_wdata = memWdata;
    assign error         = errCode;

    uart_word_packer packer (
        .clk       (clk),
        .rst       (rst),
        .clear     (packClear),
        .byteValid (packValid),
        .byteIn    (rx_data),
        .word      (word),
        .wordValid (wordValid)
    );

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            state    <= S_LEN;
            errCode  <= ERR_NONE;
            count    <= 32'd0;
            index    <= 32'd0;
            sum      <= 8'd0;
            memReq   <= 1'b0;
            memAddr  <= ADDR_WIDTH'(BASE_ADDR);
            memWdata <= 32'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            if (accepted) memReq <= 1'b0;
            unique case (state)
                S_LEN: if (packValid) begin
                    busy <= 1'b1;
                    if (wordValid) begin
                        count <= word;
                        if (word > MAX_WORDS) begin
                            state   <= S_ERR;
                            errCode <= ERR_LEN;
                            busy    <= 1'b0;
                        end else if (word == 32'd0) begin
                            state <= S_SUM;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end
                S_DATA: if (packValid) begin
                    sum <= sum ^ rx_data;
                    if (wordValid) begin
                        // A completed word with the previous write
                        // still stalled has nowhere to go.
                        if (stalled) begin
                            state   <= S_ERR;
                            errCode <= ERR_OVERRUN;
                            memReq  <= 1'b0;
                            busy    <= 1'b0;
                        end else begin
                            memReq   <= 1'b1;
                            memAddr  <= addrNext;
                            memWdata <= word;
                            index    <= index + 32'd1;
                            if (lastWord) state <= S_SUM;
                        end
                    end
                end
                S_SUM: if (rx_valid) begin
                    if (rx_data != sum) begin
                        state   <= S_ERR;
                        errCode <= ERR_SUM;
                        memReq  <= 1'b0;
                        busy    <= 1'b0;
                    end else if (stalled) begin
                        state <= S_FLUSH;
                    end else begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                S_FLUSH: if (accepted) begin
                    state <= S_DONE;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_loader.sv
// Scoreboard bench for uart_loader: directed frames, writes
// checked by a negedge monitor against an expected queue.
module tb_uart_loader;
    import uart_loader_pkg::*;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'd0;
    logic       rx_valid = 1'b0;
    logic       restart = 1'b0;
    logic       busy;
    logic       done;
    logic [1:0] error;

    int tests = 0;
    int failures = 0;
    int reqCycles = 0;
    int snap;
    wr_t expQ[$];

    uart_loader_if #(.ADDR_WIDTH(32)) memIf();

    uart_loader #(
        .BASE_ADDR  (32'h0000_0100),
        .ADDR_WIDTH (32),
        .MAX_WORDS  (32'd4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .restart  (restart),
        .mem      (memIf),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h",
                     name, act, exp);
        end
    endtask

    // Monitor: every accepted write must match the queue head.
    always @(negedge clk) begin
        wr_t e;
        if (memIf.mem_req) reqCycles++;
        if (!rst && memIf.mem_req && memIf.mem_ready) begin
            if (expQ.size() == 0) begin
                tests++;
                failures++;
                $display("FAIL unexpected_write: got %h@%h expected none",
                         memIf.mem_wdata, memIf.mem_addr);
            end else begin
                e = expQ.pop_front();
                chk("wr_addr", memIf.mem_addr, e.addr);
                chk("wr_data", memIf.mem_wdata, e.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic putByte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic putFrame(input logic [7:0] b[]);
        foreach (b[i]) putByte(b[i]);
    endtask

    task automatic pulseRestart();
        restart = 1'b1;
        tick();
        restart = 1'b0;
    endtask

    task automatic chkIdle(input string tag);
        chk({tag, "_req"},   32'(memIf.mem_req), 32'd0);
        chk({tag, "_addr"},  memIf.mem_addr, 32'h100);
        chk({tag, "_wdata"}, memIf.mem_wdata, 32'd0);
        chk({tag, "_busy"},  32'(busy), 32'd0);
        chk({tag, "_done"},  32'(done), 32'd0);
        chk({tag, "_err"},   32'(error), 32'd0);
    endtask

    task automatic pushTwo();
        expQ.push_back('{32'h100, 32'h1234_5678});
        expQ.push_back('{32'h104, 32'hDEAD_BEEF});
    endtask

    logic [7:0] fullFrame[] = '{8'h02, 8'h00, 8'h00, 8'h00,
                                8'h78, 8'h56, 8'h34, 8'h12,
                                8'hEF, 8'hBE, 8'hAD, 8'hDE,
                                8'h2A};

    initial begin
        memIf.mem_ready = 1'b1;
        tick();
        tick();
        chkIdle("reset");
        rst = 1'b0;
        tick();

        // Normal two-word load; checksum 78^56^34^12^EF^BE^AD^DE = 2A
        pushTwo();
        putFrame('{8'h02, 8'h00, 8'h00, 8'h00,
                   8'h78, 8'h56, 8'h34, 8'h12});
        chk("lat_req", 32'(memIf.mem_req), 32'd1);
        chk("lat_busy", 32'(busy), 32'd1);
        putFrame('{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2A});
        chk("norm_done", 32'(done), 32'd1);
        chk("norm_err", 32'(error), 32'd0);
        chk("norm_busy", 32'(busy), 32'd0);
        tick();
        chk("norm_req", 32'(memIf.mem_req), 32'd0);
        chk("norm_q", 32'(expQ.size()), 32'd0);

        pulseRestart();
        chkIdle("restart");

        // Empty image, good then bad checksum
        snap = reqCycles;
        putFrame('{8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
        chk("empty_done", 32'(done), 32'd1);
        chk("empty_err", 32'(error), 32'd0);
        chk("empty_noreq", 32'(reqCycles), 32'(snap));
        pulseRestart();
        putFrame('{8'h00, 8'h00, 8'h00, 8'h00, 8'h01});
        chk("esum_err", 32'(error), 32'd1);
        chk("esum_done", 32'(done), 32'd0);

        // Wrong checksum on a real frame
        pulseRestart();
        pushTwo();
        putFrame('{8'h02, 8'h00, 8'h00, 8'h00,
                   8'h78, 8'h56, 8'h34, 8'h12,
                   8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h9A});
        chk("bsum_err", 32'(error), 32'd1);
        chk("bsum_done", 32'(done), 32'd0);
        chk("bsum_q", 32'(expQ.size()), 32'd0);

        // Length above MAX_WORDS
        pulseRestart();
        snap = reqCycles;
        putFrame('{8'h05, 8'h00, 8'h00, 8'h00});
        chk("len_err", 32'(error), 32'd2);
        chk("len_busy", 32'(busy), 32'd0);
        putFrame('{8'h78, 8'h56, 8'h34, 8'h12, 8'h2A});
        chk("len_sticky", 32'(error), 32'd2);
        chk("len_done", 32'(done), 32'd0);
        chk("len_noreq", 32'(reqCycles), 32'(snap));

        // Overrun: memory never ready
        pulseRestart();
        memIf.mem_ready = 1'b0;
        putFrame('{8'h02, 8'h00, 8'h00, 8'h00,
                   8'h78, 8'h56, 8'h34, 8'h12});
        chk("ovr_req1", 32'(memIf.mem_req), 32'd1);
        putFrame('{8'hEF, 8'hBE, 8'hAD, 8'hDE});
        chk("ovr_err", 32'(error), 32'd3);
        chk("ovr_req", 32'(memIf.mem_req), 32'd0);

        // Ready exactly on the second word's last byte
        pulseRestart();
        pushTwo();
        putFrame('{8'h02, 8'h00, 8'h00, 8'h00,
                   8'h78, 8'h56, 8'h34, 8'h12,
                   8'hEF, 8'hBE, 8'hAD});
        memIf.mem_ready = 1'b1;
        putByte(8'hDE);
        memIf.mem_ready = 1'b0;
        chk("edge_err", 32'(error), 32'd0);
        chk("edge_req", 32'(memIf.mem_req), 32'd1);
        chk("edge_addr", memIf.mem_addr, 32'h104);
        chk("edge_wdata", memIf.mem_wdata, 32'hDEAD_BEEF);

        // Final write stalled across the checksum
        putByte(8'h2A);
        chk("fl_state", 32'(dut.state), 32'(S_FLUSH));
        chk("fl_done0", 32'(done), 32'd0);
        tick();
        tick();
        chk("fl_hold", 32'(done), 32'd0);
        chk("fl_busy", 32'(busy), 32'd1);
        memIf.mem_ready = 1'b1;
        tick();
        chk("fl_done", 32'(done), 32'd1);
        chk("fl_req", 32'(memIf.mem_req), 32'd0);
        chk("fl_q", 32'(expQ.size()), 32'd0);

        // Restart mid-frame, colliding with a byte
        pulseRestart();
        putFrame('{8'h02, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56});
        rx_valid = 1'b1;
        rx_data  = 8'h34;
        pulseRestart();
        rx_valid = 1'b0;
        chk("rs_busy", 32'(busy), 32'd0);
        chk("rs_addr", memIf.mem_addr, 32'h100);
        pushTwo();
        putFrame(fullFrame);
        chk("rs_done", 32'(done), 32'd1);
        chk("rs_err", 32'(error), 32'd0);
        tick();
        chk("rs_q", 32'(expQ.size()), 32'd0);

        // rst while a write is pending
        pulseRestart();
        memIf.mem_ready = 1'b0;
        putFrame('{8'h02, 8'h00, 8'h00, 8'h00,
                   8'h78, 8'h56, 8'h34, 8'h12});
        chk("rst_req1", 32'(memIf.mem_req), 32'd1);
        rst = 1'b1;
        tick();
        chkIdle("rst_mid");
        rst = 1'b0;
        memIf.mem_ready = 1'b1;
        pushTwo();
        putFrame(fullFrame);
        chk("rst_done", 32'(done), 32'd1);
        tick();
        chk("rst_q", 32'(expQ.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
